// File: rtl/dsdmnist_result_reader.sv
// Result-buffer reader for the MNIST accelerator: reads 10 FP32 scores per image,
// picks the argmax class and streams one prediction per image over valid/ready.
module dsdmnist_result_reader #(
   parameter int unsigned IMGNUM = 10,
   parameter int unsigned FPW    = 32,
   parameter int unsigned ADDRW  = 32,
   localparam int unsigned IMGW  = (IMGNUM > 1) ? $clog2(IMGNUM) : 1
) (
   input  logic             i_CLK,
   input  logic             i_RST_n,
   input  logic             i_START,
   output logic             o_RDBUF_EN,
   output logic [ADDRW-1:0] o_RDBUF_ADDR,
   input  logic [FPW-1:0]   i_RDBUF_DATA,
   output logic             o_PRED_VALID,
   input  logic             i_PRED_READY,
   output logic [3:0]       o_PRED_CLASS,
   output logic [IMGW-1:0]  o_PRED_IMG,
   output logic [FPW-1:0]   o_PRED_SCORE,
   output logic             o_BUSY,
   output logic             o_DONE
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_EMIT, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [IMGW-1:0]  img_q, img_d;
   logic [3:0]       cls_q, cls_d;
   logic             en_q, en_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic             rd_vld_q, rd_vld_d;
   logic [3:0]       rd_cls_q, rd_cls_d;
   logic [FPW-1:0]   best_score_q, best_score_d;
   logic [3:0]       best_cls_q, best_cls_d;
   logic             pvalid_q, pvalid_d;
   logic [3:0]       pclass_q, pclass_d;
   logic [IMGW-1:0]  pimg_q, pimg_d;
   logic [FPW-1:0]   pscore_q, pscore_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [ADDRW-1:0] word_idx;

   // Maps IEEE-754 bit patterns onto an unsigned total order (-0 sorts below +0).
   function automatic logic [FPW-1:0] order_key(input logic [FPW-1:0] x);
      return x[FPW-1] ? ~x : {1'b1, x[FPW-2:0]};
   endfunction

   always_comb begin
      state_d      = state_q;
      img_d        = img_q;
      cls_d        = cls_q;
      en_d         = 1'b0;
      addr_d       = addr_q;
      rd_vld_d     = en_q;
      rd_cls_d     = cls_q;
      best_score_d = best_score_q;
      best_cls_d   = best_cls_q;
      pvalid_d     = pvalid_q;
      pclass_d     = pclass_q;
      pimg_d       = pimg_q;
      pscore_d     = pscore_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      word_idx     = '0;

      // Compare stage trails address issue by one cycle; class 0 seeds the running best.
      if (rd_vld_q && (rd_cls_q == 4'd0 ||
                       order_key(i_RDBUF_DATA) > order_key(best_score_q))) begin
         best_score_d = i_RDBUF_DATA;
         best_cls_d   = rd_cls_q;
      end

      case (state_q)
         S_IDLE: begin
            if (i_START) begin
               state_d = S_READ;
               img_d   = '0;
               cls_d   = 4'd0;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_READ: begin
            if (cls_q == 4'd9) begin
               state_d = S_LAST;
            end else begin
               cls_d = cls_q + 4'd1;
               en_d  = 1'b1;
            end
         end
         S_LAST: begin
            state_d  = S_EMIT;
            pvalid_d = 1'b1;
            pclass_d = best_cls_d;
            pscore_d = best_score_d;
            pimg_d   = img_q;
         end
         S_EMIT: begin
            if (i_PRED_READY) begin
               pvalid_d = 1'b0;
               if (img_q < IMGW'(IMGNUM - 1)) begin
                  state_d = S_READ;
                  img_d   = img_q + IMGW'(1);
                  cls_d   = 4'd0;
                  en_d    = 1'b1;
               end else begin
                  state_d = S_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      word_idx = ADDRW'(img_d) * ADDRW'(10) + ADDRW'(cls_d);
      if (en_d) begin
         addr_d = word_idx << 2;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q      <= S_IDLE;
         img_q        <= '0;
         cls_q        <= '0;
         en_q         <= 1'b0;
         addr_q       <= '0;
         rd_vld_q     <= 1'b0;
         rd_cls_q     <= '0;
         best_score_q <= '0;
         best_cls_q   <= '0;
         pvalid_q     <= 1'b0;
         pclass_q     <= '0;
         pimg_q       <= '0;
         pscore_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         img_q        <= img_d;
         cls_q        <= cls_d;
         en_q         <= en_d;
         addr_q       <= addr_d;
         rd_vld_q     <= rd_vld_d;
         rd_cls_q     <= rd_cls_d;
         best_score_q <= best_score_d;
         best_cls_q   <= best_cls_d;
         pvalid_q     <= pvalid_d;
         pclass_q     <= pclass_d;
         pimg_q       <= pimg_d;
         pscore_q     <= pscore_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign o_RDBUF_EN   = en_q;
   assign o_RDBUF_ADDR = addr_q;
   assign o_PRED_VALID = pvalid_q;
   assign o_PRED_CLASS = pclass_q;
   assign o_PRED_IMG   = pimg_q;
   assign o_PRED_SCORE = pscore_q;
   assign o_BUSY       = busy_q;
   assign o_DONE       = done_q;

endmodule
